// File: rtl/pick_bits.sv
// pick_bits: serialises the active bits of a latched vector as one index per
// valid/ready beat, lowest first, with burst count, rank and last/zero flags.
module pick_bits #(
    parameter int IN = 32,
    parameter logic ACT = 1'b1,
    localparam int OUT = (IN > 1) ? $clog2(IN) : 1,
    localparam int CNT = $clog2(IN) + 1
) (
    input  logic           clk,
    input  logic           reset_,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [IN-1:0]  in,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [OUT-1:0] out_idx,
    output logic [CNT-1:0] out_rank,
    output logic [CNT-1:0] out_cnt,
    output logic           out_last,
    output logic           out_zero
);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t state, state_nxt;
    logic [IN-1:0] mask, act_mask, lsb;
    logic [CNT-1:0] rank, cnt, pop;
    logic [OUT-1:0] idx;
    logic zero, busy, accept, fire;
    assign busy = (state == BUSY);
    assign accept = !busy && in_valid;
    assign fire = busy && out_ready;
    assign in_ready = !busy;
    assign out_valid = busy;
    // at most one bit left in the remaining mask (covers the empty vector too)
    assign out_last = busy && ((mask & (mask - 1'b1)) == '0);
    assign out_idx = idx;
    assign out_rank = rank;
    assign out_cnt = cnt;
    assign out_zero = zero;
    always_comb begin
        act_mask = ACT ? in : ~in;
        lsb = mask & (~mask + 1'b1);
        pop = '0;
        idx = '0;
        for (int i = 0; i < IN; i++) begin
            pop = pop + CNT'(act_mask[i]);
            idx = lsb[i] ? (idx | OUT'(i)) : idx;
        end
        state_nxt = accept ? BUSY : (fire && out_last) ? IDLE : state;
    end
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state <= IDLE;
            mask <= '0;
            rank <= '0;
            cnt <= '0;
            zero <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                mask <= act_mask;
                cnt <= pop;
                zero <= (pop == '0);
                rank <= '0;
            end else if (fire) begin
                mask <= mask & ~lsb;
                // rank stays on the final ordinal so it never passes cnt-1
                if (!out_last) rank <= rank + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_pick_bits.sv
// tb_pick_bits: randomized checks of two 8-bit pick_bits instances (active-high
// and active-low) against a queue-based reference of expected beats.
module tb_pick_bits;
    logic clk = 1'b0;
    logic reset_ = 1'b0;
    logic [7:0] in_v = '0;
    logic in_valid [2];
    logic in_ready [2];
    logic out_valid [2];
    logic out_ready [2];
    logic [2:0] out_idx [2];
    logic [3:0] out_rank [2];
    logic [3:0] out_cnt [2];
    logic out_last [2];
    logic out_zero [2];
    int checks = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pick_bits #(.IN(8), .ACT(1'b1)) u_hi (
        .clk(clk), .reset_(reset_), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in(in_v), .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_idx(out_idx[0]),
        .out_rank(out_rank[0]), .out_cnt(out_cnt[0]), .out_last(out_last[0]), .out_zero(out_zero[0])
    );
    pick_bits #(.IN(8), .ACT(1'b0)) u_lo (
        .clk(clk), .reset_(reset_), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in(in_v), .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_idx(out_idx[1]),
        .out_rank(out_rank[1]), .out_cnt(out_cnt[1]), .out_last(out_last[1]), .out_zero(out_zero[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // mode 0: consumer always ready; mode 1: random ready. stall0 forces stalls on beat 0.
    task automatic send(input int s, input logic [7:0] v, input int mode, input int stall0);
        int q[$];
        int n, stalls;
        logic r;
        for (int i = 0; i < 8; i++)
            if (v[i] == (s == 0)) q.push_back(i);
        n = q.size();
        @(negedge clk);
        chk("idle_in_ready", in_ready[s], 1);
        chk("idle_out_valid", out_valid[s], 0);
        in_v = v;
        in_valid[s] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid[s] = 1'b0;
        for (int k = 0; k < ((n == 0) ? 1 : n); k++) begin
            stalls = 0;
            do begin
                chk("out_valid", out_valid[s], 1);
                chk("in_ready_busy", in_ready[s], 0);
                chk("out_idx", out_idx[s], (n == 0) ? 0 : q[k]);
                chk("out_rank", out_rank[s], k);
                chk("out_cnt", out_cnt[s], n);
                chk("out_last", out_last[s], (n == 0) || (k == n - 1));
                chk("out_zero", out_zero[s], n == 0);
                r = (k == 0 && stalls < stall0) ? 1'b0 :
                    (mode == 0 || stalls >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
                if (!r) begin
                    stalls++;
                    in_v = 8'hFF;
                    in_valid[s] = 1'b1;
                end
                out_ready[s] = r;
                @(posedge clk);
                @(negedge clk);
                in_valid[s] = 1'b0;
                out_ready[s] = 1'b0;
            end while (!r);
        end
        chk("done_out_valid", out_valid[s], 0);
        chk("done_in_ready", in_ready[s], 1);
        chk("done_out_last", out_last[s], 0);
        chk("done_out_cnt", out_cnt[s], n);
        chk("done_out_zero", out_zero[s], n == 0);
    endtask

    initial begin
        logic [7:0] v;
        for (int s = 0; s < 2; s++) begin
            in_valid[s] = 1'b0;
            out_ready[s] = 1'b0;
        end
        #3;
        chk("rst_in_ready", in_ready[0], 1);
        chk("rst_out_valid", out_valid[0], 0);
        chk("rst_out_cnt", out_cnt[0], 0);
        chk("rst_out_idx", out_idx[0], 0);
        chk("rst_out_last", out_last[0], 0);
        chk("rst_out_zero", out_zero[0], 0);
        chk("rst_out_rank", out_rank[0], 0);
        @(negedge clk);
        reset_ = 1'b1;
        send(0, 8'b1010_0100, 0, 0);
        send(0, 8'h00, 0, 0);
        send(0, 8'b0010_0001, 0, 3);
        send(1, 8'b1111_1110, 0, 0);
        send(1, 8'hFF, 1, 0);
        send(0, 8'hFF, 1, 1);
        // reset in the middle of a burst
        @(negedge clk);
        in_v = 8'hFF;
        in_valid[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid[0] = 1'b0;
        out_ready[0] = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("mid_pre_rank", out_rank[0], 2);
        #2 reset_ = 1'b0;
        #1;
        chk("mid_out_valid", out_valid[0], 0);
        chk("mid_in_ready", in_ready[0], 1);
        chk("mid_out_cnt", out_cnt[0], 0);
        chk("mid_out_rank", out_rank[0], 0);
        chk("mid_out_idx", out_idx[0], 0);
        chk("mid_out_last", out_last[0], 0);
        @(negedge clk);
        out_ready[0] = 1'b0;
        chk("mid_hold_valid", out_valid[0], 0);
        reset_ = 1'b1;
        send(0, 8'b1000_0000, 0, 0);
        for (int t = 0; t < 60; t++) begin
            v = 8'($urandom);
            if (t % 4 == 1) v = v & 8'($urandom) & 8'($urandom);
            if (t % 4 == 3) v = v | 8'($urandom) | 8'($urandom);
            if (t % 11 == 5) v = (t % 2 == 0) ? 8'h00 : 8'hFF;
            send(t % 2, v, 1, $urandom_range(0, 2));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
